// File: rtl/smm_pkg.sv
// Shared constants and types for the Strassen core operand loader.
package smm_pkg;

    localparam int unsigned DATAWIDTH = 32;
    localparam int unsigned BUSWIDTH  = 4 * DATAWIDTH;

    // Lane MSB positions on the packed A/B buses
    localparam int unsigned LANE_00 = DATAWIDTH - 1;
    localparam int unsigned LANE_01 = 2 * DATAWIDTH - 1;
    localparam int unsigned LANE_10 = 3 * DATAWIDTH - 1;
    localparam int unsigned LANE_11 = 4 * DATAWIDTH - 1;

    localparam int unsigned BEATS_PER_GROUP = 8;

    localparam logic [2:0] BEAT_A00 = 3'd0;
    localparam logic [2:0] BEAT_A01 = 3'd1;
    localparam logic [2:0] BEAT_A10 = 3'd2;
    localparam logic [2:0] BEAT_A11 = 3'd3;
    localparam logic [2:0] BEAT_B00 = 3'd4;
    localparam logic [2:0] BEAT_B01 = 3'd5;
    localparam logic [2:0] BEAT_B10 = 3'd6;
    localparam logic [2:0] BEAT_B11 = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/smm_operand_loader_if.sv
// Element stream in, packed operand buses and load/hold status out.
interface smm_operand_loader_if #(
    parameter int unsigned DATAWIDTH = smm_pkg::DATAWIDTH
);
    localparam int unsigned BUSWIDTH = 4 * DATAWIDTH;

    logic                 in_valid;
    logic                 in_ready;
    logic [DATAWIDTH-1:0] in_data;
    logic                 in_sel;
    logic [BUSWIDTH-1:0]  A;
    logic [BUSWIDTH-1:0]  B;
    logic                 load;
    logic                 sel;
    logic                 busy;
    logic                 done;

    modport master (
        output in_valid, in_data, in_sel,
        input  in_ready, A, B, load, sel, busy, done
    );

    modport slave (
        input  in_valid, in_data, in_sel,
        output in_ready, A, B, load, sel, busy, done
    );

endinterface

// File: rtl/smm_stage_buf.sv
// Staging bank: collects one 8-beat A/B group while the active pair is held.
module smm_stage_buf
    import smm_pkg::*;
#(
    parameter int unsigned DW = smm_pkg::DATAWIDTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    input  logic [DW-1:0]   in_data_i,
    input  logic            in_sel_i,
    input  logic            clear_i,
    output logic            in_ready_o,
    output logic [4*DW-1:0] stg_a_o,
    output logic [4*DW-1:0] stg_b_o,
    output logic            stg_sel_o,
    output logic            stg_full_o
);

    logic [2:0]    beat_q;
    logic [DW-1:0] bank_q [BEATS_PER_GROUP];
    logic          sel_q;
    logic          full_q;
    logic          hs_c;

    assign in_ready_o = !full_q && !rst;
    assign hs_c       = in_valid_i && in_ready_o;

    // Beat counter wraps 7 -> 0; the last beat marks the bank full
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q <= '0;
            sel_q  <= 1'b0;
            full_q <= 1'b0;
            for (int i = 0; i < int'(BEATS_PER_GROUP); i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            if (hs_c) begin
                bank_q[beat_q] <= in_data_i;
                beat_q         <= beat_q + 3'd1;
                if (beat_q == BEAT_A00) begin
                    sel_q <= in_sel_i;
                end
            end
            if (hs_c && (beat_q == BEAT_B11)) begin
                full_q <= 1'b1;
            end else if (clear_i) begin
                full_q <= 1'b0;
            end
        end
    end

    assign stg_a_o    = {bank_q[BEAT_A11], bank_q[BEAT_A10], bank_q[BEAT_A01], bank_q[BEAT_A00]};
    assign stg_b_o    = {bank_q[BEAT_B11], bank_q[BEAT_B10], bank_q[BEAT_B01], bank_q[BEAT_B00]};
    assign stg_sel_o  = sel_q;
    assign stg_full_o = full_q;

endmodule

// File: rtl/smm_operand_loader.sv
// Operand stager: moves a staged A/B/sel group onto the core buses and holds it
// for the compute window, with back-to-back transfers when the next group is ready.
module smm_operand_loader
    import smm_pkg::*;
#(
    parameter int unsigned DATAWIDTH   = smm_pkg::DATAWIDTH,
    parameter int unsigned BLOCKSIZE   = DATAWIDTH,
    parameter int unsigned BUSWIDTH    = BLOCKSIZE * 4,
    parameter int unsigned HOLD_CYCLES = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    smm_operand_loader_if.slave  bus
);

    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("smm_operand_loader: HOLD_CYCLES must be >= 1");
    end
    if ((BLOCKSIZE != DATAWIDTH) || (BUSWIDTH != 4 * BLOCKSIZE)) begin : g_bad_width
        $error("smm_operand_loader: BUSWIDTH must be 4*BLOCKSIZE with BLOCKSIZE == DATAWIDTH");
    end

    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [BUSWIDTH-1:0] a_q;
    logic [BUSWIDTH-1:0] b_q;
    logic                sel_q;
    logic                load_q;
    logic                busy_q;
    logic                done_q;

    logic [BUSWIDTH-1:0] stg_a;
    logic [BUSWIDTH-1:0] stg_b;
    logic                stg_sel;
    logic                stg_full;
    logic                xfer_c;

    smm_stage_buf #(.DW(DATAWIDTH)) u_stage (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (bus.in_valid),
        .in_data_i  (bus.in_data),
        .in_sel_i   (bus.in_sel),
        .clear_i    (xfer_c),
        .in_ready_o (bus.in_ready),
        .stg_a_o    (stg_a),
        .stg_b_o    (stg_b),
        .stg_sel_o  (stg_sel),
        .stg_full_o (stg_full)
    );

    // Transfer from IDLE, or at the final hold cycle for back-to-back loads
    assign xfer_c = stg_full && ((state_q == IDLE) || (cnt_q == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= 1'b0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            load_q <= 1'b0;
            done_q <= 1'b0;
            if (xfer_c) begin
                a_q     <= stg_a;
                b_q     <= stg_b;
                sel_q   <= stg_sel;
                load_q  <= 1'b1;
                cnt_q   <= CNT_W'(HOLD_CYCLES - 1);
                state_q <= HOLD;
                busy_q  <= 1'b1;
                done_q  <= (HOLD_CYCLES == 1);
            end else if (state_q == HOLD) begin
                if (cnt_q != '0) begin
                    cnt_q  <= cnt_q - CNT_W'(1);
                    done_q <= (cnt_q == CNT_W'(1));
                end else begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            end
        end
    end

    assign bus.A    = a_q;
    assign bus.B    = b_q;
    assign bus.sel  = sel_q;
    assign bus.load = load_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
